// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream XOR stage.
package rc4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int BYTE_W = 8;

  // Pointer carries one extra wrap bit so full and empty can be told apart.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small keystream byte FIFO with a combinationally visible head entry.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/rc4_xor_stream.sv
// XORs a data byte stream with buffered RC4 keystream, with optional drop[N].
// state | meaning: IDLE wait start | DROP discard keystream | RUN xor bytes | DONE completion pulse
module rc4_xor_stream
  import rc4_pkg::*;
#(
  parameter int KS_DEPTH = 4,
  parameter int LEN_W    = 16,
  parameter int DROP_N   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  msg_len_i,
  input  logic              ks_valid_i,
  input  logic [BYTE_W-1:0] ks_data_i,
  output logic              ks_ready_o,
  input  logic              din_valid_i,
  input  logic [BYTE_W-1:0] din_data_i,
  output logic              din_ready_o,
  output logic              dout_valid_o,
  output logic [BYTE_W-1:0] dout_data_o,
  input  logic              dout_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  byte_cnt_o
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [LEN_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              dout_valid_q, dout_valid_d;
  logic [BYTE_W-1:0] dout_data_q, dout_data_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_head;

  rc4_ks_fifo #(.DEPTH(KS_DEPTH)) u_ks_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (ks_data_i),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      fetch_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      fetch_cnt_q  <= fetch_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    fetch_cnt_d  = fetch_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    ks_ready_o   = 1'b0;
    din_ready_o  = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d       = msg_len_i;
          byte_cnt_d  = '0;
          fetch_cnt_d = '0;
          if (msg_len_i == '0) begin
            state_d = ST_DONE;
          end else if (DROP_N > 0) begin
            drop_cnt_d = LEN_W'(DROP_N);
            state_d    = ST_DROP;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DROP: begin
        ks_ready_o = 1'b1;
        if (ks_valid_i) begin
          drop_cnt_d = drop_cnt_q - ONE;
          if (drop_cnt_q == ONE) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Fetch only what the message still needs so the generator never loses bytes.
        ks_ready_o  = !fifo_full && (fetch_cnt_q < len_q);
        din_ready_o = !fifo_empty && (byte_cnt_q < len_q) &&
                      (!dout_valid_q || dout_ready_i);
        if (ks_valid_i && ks_ready_o) begin
          fifo_push   = 1'b1;
          fetch_cnt_d = fetch_cnt_q + ONE;
        end
        if (din_valid_i && din_ready_o) begin
          fifo_pop     = 1'b1;
          dout_data_d  = din_data_i ^ fifo_head;
          dout_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_q + ONE;
        end else if (dout_valid_q && dout_ready_i) begin
          dout_valid_d = 1'b0;
          if (byte_cnt_q == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dout_valid_o = dout_valid_q;
  assign dout_data_o  = dout_data_q;
  assign byte_cnt_o   = byte_cnt_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);

endmodule
